// File: rtl/tug_referee.sv
// -----------------------------------------------------------------------------
// tug_referee
//
// Round controller for the tug-of-war game. Sequences each round through
// IDLE -> READY (countdown) -> PLAY -> VICTORY (cheer) -> IDLE, arbitrates
// the two players' push pulses onto a 7-position rope marker, and flags
// the winner to the cheer/LED back end. All phase timing is counted in
// ticks of the shared slowen enable.
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst      in   asynchronous active-low reset
//   slowen   in   one-clk slow tick enable (countdown and cheer timing)
//   start    in   one-clk round-start pulse, honoured only in IDLE
//   pushL    in   left player push pulse (synchronised, one-pulsed)
//   pushR    in   right player push pulse (synchronised, one-pulsed)
//   score    out  [6:0] one-hot rope marker, bit6 = left end, bit0 = right end
//   wingame  out  one-clk pulse on entry to VICTORY
//   winner   out  0 = left won, 1 = right won; held until the next victory
//   phase    out  [1:0] 00 IDLE, 01 READY, 10 PLAY, 11 VICTORY
// -----------------------------------------------------------------------------
module tug_referee #(
    parameter int READY_TICKS = 4,  // slowen ticks of countdown (1..15)
    parameter int CHEER_TICKS = 8   // slowen ticks of victory cheer (1..15)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slowen,
    input  logic       start,
    input  logic       pushL,
    input  logic       pushR,
    output logic [6:0] score,
    output logic       wingame,
    output logic       winner,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        PH_IDLE    = 2'b00,
        PH_READY   = 2'b01,
        PH_PLAY    = 2'b10,
        PH_VICTORY = 2'b11
    } phase_t;

    localparam logic [2:0] POS_CENTRE = 3'd3;
    localparam logic [2:0] POS_LEFT   = 3'd6;
    localparam logic [2:0] POS_RIGHT  = 3'd0;
    localparam logic [3:0] READY_LIM  = 4'(READY_TICKS);
    localparam logic [3:0] CHEER_LIM  = 4'(CHEER_TICKS);

    phase_t     r_phase;
    logic [2:0] r_pos;
    logic [3:0] r_cnt;
    logic [6:0] r_score;
    logic       r_wingame;
    logic       r_winner;

    phase_t     w_phase_nxt;
    logic [2:0] w_pos_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_wingame_nxt;
    logic       w_winner_nxt;

    logic       w_only_l;
    logic       w_only_r;
    logic [3:0] w_cnt_inc;
    logic       w_in_round;

    // Simultaneous pushes cancel, so only a lone push ever moves the rope.
    assign w_only_l   = pushL & ~pushR;
    assign w_only_r   = pushR & ~pushL;
    assign w_cnt_inc  = r_cnt + 4'd1;
    assign w_in_round = (r_phase == PH_READY) || (r_phase == PH_PLAY);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_phase_nxt   = r_phase;
        w_pos_nxt     = r_pos;
        w_cnt_nxt     = r_cnt;
        w_wingame_nxt = 1'b0;
        w_winner_nxt  = r_winner;

        case (r_phase)
            PH_IDLE: begin
                if (start) begin
                    w_phase_nxt = PH_READY;
                    w_cnt_nxt   = 4'd0;
                    w_pos_nxt   = POS_CENTRE;
                end
            end

            PH_READY: begin
                // A false start hands the opponent one step.
                if (w_only_l) begin
                    w_pos_nxt = r_pos - 3'd1;
                end else if (w_only_r) begin
                    w_pos_nxt = r_pos + 3'd1;
                end
                if (slowen) begin
                    if (w_cnt_inc == READY_LIM) begin
                        w_phase_nxt = PH_PLAY;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end

            PH_PLAY: begin
                if (w_only_l) begin
                    w_pos_nxt = r_pos + 3'd1;
                end else if (w_only_r) begin
                    w_pos_nxt = r_pos - 3'd1;
                end
            end

            PH_VICTORY: begin
                if (slowen) begin
                    if (w_cnt_inc == CHEER_LIM) begin
                        w_phase_nxt = PH_IDLE;
                        w_pos_nxt   = POS_CENTRE;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end

            default: begin
                w_phase_nxt = PH_IDLE;
                w_pos_nxt   = POS_CENTRE;
                w_cnt_nxt   = 4'd0;
            end
        endcase

        // Reaching an end overrides the countdown expiry decided above. The
        // rope only moves in READY/PLAY and those phases only ever hold
        // positions 1..5, so pos cannot step past either end.
        if (w_in_round && ((w_pos_nxt == POS_LEFT) || (w_pos_nxt == POS_RIGHT))) begin
            w_phase_nxt   = PH_VICTORY;
            w_cnt_nxt     = 4'd0;
            w_wingame_nxt = 1'b1;
            w_winner_nxt  = (w_pos_nxt == POS_RIGHT);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase   <= PH_IDLE;
            r_pos     <= POS_CENTRE;
            r_cnt     <= 4'd0;
            r_score   <= 7'b0001000;
            r_wingame <= 1'b0;
            r_winner  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_phase   <= w_phase_nxt;
            r_pos     <= w_pos_nxt;
            r_cnt     <= w_cnt_nxt;
            r_score   <= 7'b0000001 << w_pos_nxt;
            r_wingame <= w_wingame_nxt;
            r_winner  <= w_winner_nxt;
        end
    end

    assign score   = r_score;
    assign wingame = r_wingame;
    assign winner  = r_winner;
    assign phase   = r_phase;

endmodule

// File: tb/tb_tug_referee.sv
// -----------------------------------------------------------------------------
// tb_tug_referee
//
// Directed-vector bench for tug_referee with READY_TICKS=4, CHEER_TICKS=8.
// Inputs change 1 ns after a rising edge and outputs are sampled there too,
// so every observation sits well away from the active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tug_referee;

    logic       clk;
    logic       rst;
    logic       slowen;
    logic       start;
    logic       pushL;
    logic       pushR;
    logic [6:0] score;
    logic       wingame;
    logic       winner;
    logic [1:0] phase;

    int checks   = 0;
    int failures = 0;

    tug_referee #(
        .READY_TICKS(4),
        .CHEER_TICKS(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .slowen (slowen),
        .start  (start),
        .pushL  (pushL),
        .pushR  (pushR),
        .score  (score),
        .wingame(wingame),
        .winner (winner),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle of stimulus: apply inputs, pass one rising edge, settle.
    task automatic cyc(input logic s, input logic sl, input logic l, input logic r);
        start  = s;
        slowen = sl;
        pushL  = l;
        pushR  = r;
        @(posedge clk);
        #1;
        start  = 1'b0;
        slowen = 1'b0;
        pushL  = 1'b0;
        pushR  = 1'b0;
    endtask

    task automatic slow_ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (score !== 7'b0001000) begin failures++; $display("FAIL reset_score got=%b exp=%b", score, 7'b0001000); end
        checks++; if (phase !== 2'b00) begin failures++; $display("FAIL reset_phase got=%b exp=%b", phase, 2'b00); end
        checks++; if (wingame !== 1'b0) begin failures++; $display("FAIL reset_wingame got=%b exp=0", wingame); end
        checks++; if (winner !== 1'b0) begin failures++; $display("FAIL reset_winner got=%b exp=0", winner); end
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (score !== 7'b0001000) begin failures++; $display("FAIL idle_pushL_score got=%b exp=%b", score, 7'b0001000); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (score !== 7'b0001000) begin failures++; $display("FAIL idle_pushR_score got=%b exp=%b", score, 7'b0001000); end
        checks++; if (phase !== 2'b00 || wingame !== 1'b0) begin failures++; $display("FAIL idle_phase_wingame got=%b/%b exp=00/0", phase, wingame); end
    endtask

    task automatic test_countdown;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (phase !== 2'b01) begin failures++; $display("FAIL cd_after_start phase got=%b exp=01", phase); end
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            checks++; if (phase !== 2'b01) begin failures++; $display("FAIL cd_tick%0d phase got=%b exp=01", i, phase); end
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (phase !== 2'b10) begin failures++; $display("FAIL cd_tick4 phase got=%b exp=10", phase); end
        checks++; if (score !== 7'b0001000) begin failures++; $display("FAIL cd_score got=%b exp=%b", score, 7'b0001000); end
    endtask

    task automatic test_left_win;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (score !== 7'b0010000) begin failures++; $display("FAIL lw_push1 score got=%b exp=%b", score, 7'b0010000); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (score !== 7'b0100000) begin failures++; $display("FAIL lw_push2 score got=%b exp=%b", score, 7'b0100000); end
        checks++; if (wingame !== 1'b0) begin failures++; $display("FAIL lw_push2 wingame got=%b exp=0", wingame); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (score !== 7'b1000000) begin failures++; $display("FAIL lw_push3 score got=%b exp=%b", score, 7'b1000000); end
        checks++; if (phase !== 2'b11) begin failures++; $display("FAIL lw_phase got=%b exp=11", phase); end
        checks++; if (wingame !== 1'b1) begin failures++; $display("FAIL lw_wingame_high got=%b exp=1", wingame); end
        checks++; if (winner !== 1'b0) begin failures++; $display("FAIL lw_winner got=%b exp=0", winner); end
        // start and a push during the cheer are both ignored
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (wingame !== 1'b0) begin failures++; $display("FAIL lw_wingame_low got=%b exp=0", wingame); end
        checks++; if (score !== 7'b1000000 || phase !== 2'b11) begin failures++; $display("FAIL lw_victory_hold score/phase got=%b/%b exp=1000000/11", score, phase); end
        slow_ticks(7);
        checks++; if (phase !== 2'b11) begin failures++; $display("FAIL lw_cheer7 phase got=%b exp=11", phase); end
        slow_ticks(1);
        checks++; if (phase !== 2'b00) begin failures++; $display("FAIL lw_cheer8 phase got=%b exp=00", phase); end
        checks++; if (score !== 7'b0001000) begin failures++; $display("FAIL lw_cheer8 score got=%b exp=%b", score, 7'b0001000); end
        checks++; if (winner !== 1'b0) begin failures++; $display("FAIL lw_cheer8 winner got=%b exp=0", winner); end
    endtask

    task automatic test_arbitration;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        slow_ticks(4);
        // both pushes cancel; slowen in PLAY is inert
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if (score !== 7'b0001000) begin failures++; $display("FAIL arb_both score got=%b exp=%b", score, 7'b0001000); end
        checks++; if (phase !== 2'b10) begin failures++; $display("FAIL arb_play phase got=%b exp=10", phase); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (score !== 7'b0000100) begin failures++; $display("FAIL arb_pushR score got=%b exp=%b", score, 7'b0000100); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (score !== 7'b0000001 || phase !== 2'b11) begin failures++; $display("FAIL arb_rwin score/phase got=%b/%b exp=0000001/11", score, phase); end
        checks++; if (winner !== 1'b1 || wingame !== 1'b1) begin failures++; $display("FAIL arb_rwin winner/wingame got=%b/%b exp=1/1", winner, wingame); end
        slow_ticks(8);
        checks++; if (phase !== 2'b00 || winner !== 1'b1) begin failures++; $display("FAIL arb_idle phase/winner got=%b/%b exp=00/1", phase, winner); end
    endtask

    task automatic test_false_start;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (winner !== 1'b1) begin failures++; $display("FAIL fs_start_keeps_winner got=%b exp=1", winner); end
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (score !== 7'b0001000) begin failures++; $display("FAIL fs_both score got=%b exp=%b", score, 7'b0001000); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (score !== 7'b0010000 || phase !== 2'b01) begin failures++; $display("FAIL fs_r1 score/phase got=%b/%b exp=0010000/01", score, phase); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (score !== 7'b0100000 || phase !== 2'b01) begin failures++; $display("FAIL fs_r2 score/phase got=%b/%b exp=0100000/01", score, phase); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (score !== 7'b1000000 || phase !== 2'b11) begin failures++; $display("FAIL fs_r3 score/phase got=%b/%b exp=1000000/11", score, phase); end
        checks++; if (winner !== 1'b0 || wingame !== 1'b1) begin failures++; $display("FAIL fs_r3 winner/wingame got=%b/%b exp=0/1", winner, wingame); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (wingame !== 1'b0) begin failures++; $display("FAIL fs_wingame_once got=%b exp=0", wingame); end
        slow_ticks(8);
        checks++; if (phase !== 2'b00) begin failures++; $display("FAIL fs_idle phase got=%b exp=00", phase); end
    endtask

    task automatic test_back_to_back;
        // victory beats countdown expiry in the same cycle
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        slow_ticks(3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (score !== 7'b0100000 || phase !== 2'b01) begin failures++; $display("FAIL pri_setup score/phase got=%b/%b exp=0100000/01", score, phase); end
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (phase !== 2'b11 || score !== 7'b1000000) begin failures++; $display("FAIL pri_victory phase/score got=%b/%b exp=11/1000000", phase, score); end
        slow_ticks(8);
        // false start plus expiry: move applies and PLAY still opens
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        slow_ticks(3);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (phase !== 2'b10 || score !== 7'b0000100) begin failures++; $display("FAIL fs_expiry phase/score got=%b/%b exp=10/0000100", phase, score); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (score !== 7'b0001000) begin failures++; $display("FAIL play_after_fs score got=%b exp=%b", score, 7'b0001000); end
    endtask

    task automatic test_async_reset;
        // continues from PLAY at the centre position
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (score !== 7'b0000001 || winner !== 1'b1 || wingame !== 1'b1) begin failures++; $display("FAIL ar_rwin score/winner/wingame got=%b/%b/%b exp=0000001/1/1", score, winner, wingame); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (phase !== 2'b00 || score !== 7'b0001000) begin failures++; $display("FAIL ar_immediate phase/score got=%b/%b exp=00/0001000", phase, score); end
        checks++; if (winner !== 1'b0 || wingame !== 1'b0) begin failures++; $display("FAIL ar_immediate winner/wingame got=%b/%b exp=0/0", winner, wingame); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (phase !== 2'b01) begin failures++; $display("FAIL ar_restart phase got=%b exp=01", phase); end
        slow_ticks(4);
        checks++; if (phase !== 2'b10) begin failures++; $display("FAIL ar_play phase got=%b exp=10", phase); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (score !== 7'b0010000) begin failures++; $display("FAIL ar_pushL score got=%b exp=%b", score, 7'b0010000); end
    endtask

    initial begin
        rst    = 1'b0;
        slowen = 1'b0;
        start  = 1'b0;
        pushL  = 1'b0;
        pushR  = 1'b0;
        test_reset;
        test_countdown;
        test_left_win;
        test_arbitration;
        test_false_start;
        test_back_to_back;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tug_referee.md
Name: tug_referee

Overview:
- Round controller for the tug-of-war game. It sequences each round through idle, countdown, play and victory-cheer phases.
- It arbitrates the two players' synchronised, one-pulsed push inputs onto a single 7-position rope marker.
- It drives the score vector and the one-cycle wingame pulse consumed by the victory cheer block.
- It sits between the per-player SYNC/OPP front ends and the CheerVictory/LED back end. All timing comes from the shared slowen tick.

Parameters:
- READY_TICKS, 4, number of slowen ticks in the countdown phase before play opens (1..15).
- CHEER_TICKS, 8, number of slowen ticks the VICTORY phase is held before returning to IDLE (1..15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately.
- slowen  input  1  one-clk-wide slow tick enable, used for countdown and cheer timing.
- start  input  1  one-clk-wide round-start pulse.
- pushL  input  1  left player push, one-clk pulse, already synchronised.
- pushR  input  1  right player push, one-clk pulse, already synchronised.
- score  output  7  one-hot rope marker; bit6 = left end, bit0 = right end.
- wingame  output  1  one-clk pulse on entry to VICTORY.
- winner  output  1  0 = left won, 1 = right won; valid from the wingame cycle until the next start.
- phase  output  2  00 IDLE, 01 READY, 10 PLAY, 11 VICTORY.

Behaviour:
- Reset values (rst=0, asynchronous): phase=IDLE, pos=3, score=7'b0001000, wingame=0, winner=0, tick counter=0.
- score is always 1<<pos, registered. pos ranges 0..6.
- Moves are applied at the sampling edge and are visible on score in the following cycle (latency 1).
  - pushL alone: pos+1.
  - pushR alone: pos-1.
  - pushL and pushR in the same cycle: cancel, no move.
- IDLE:
  - Pushes are ignored.
  - start: phase goes to READY, counter=0, pos=3.
- READY:
  - Each slowen increments the counter.
  - On the slowen that makes counter==READY_TICKS, phase goes to PLAY and counter clears.
  - False start: a push in READY moves the rope one step in the opponent's favour (pushL gives pos-1, pushR gives pos+1).
  - Simultaneous L+R false starts cancel.
  - A false start and countdown expiry in the same cycle: apply the move and still enter PLAY.
- PLAY:
  - Pushes move the rope per the rules above. slowen has no effect.
  - The counter does not run.
- Victory detection, in READY or PLAY:
  - A move making pos==6 gives left victory (winner=0). pos==0 gives right victory (winner=1).
  - At that edge: phase=VICTORY, score shows the end position, counter=0, wingame=1.
  - wingame deasserts at the next edge (exactly one cycle high).
  - Victory takes priority over the READY to PLAY transition in the same cycle.
- VICTORY:
  - Pushes and start are ignored. score holds the end position.
  - Each slowen increments the counter.
  - On the slowen that makes counter==CHEER_TICKS: phase=IDLE, pos=3, counter=0. winner holds.
- start outside IDLE is ignored. start in IDLE clears nothing except pos/counter; winner is overwritten only at the next victory.
- pos never leaves 0..6. Victory is entered before any further move can apply at an end.
- Reset mid-round, in any phase: immediate return to reset values. A wingame in flight is dropped.
- No latches. Counter width is 4 bits.

Test Plan:
- Reset/idle: hold rst=0 for 2 clk, release, pulse pushL/pushR → score=7'b0001000, phase=00, wingame=0 throughout.
- Countdown: start pulse, then 4 slowen pulses (READY_TICKS=4) → phase 01 after start; 10 in the cycle after the 4th slowen; score unchanged at 7'b0001000.
- Left win: in PLAY, 3 pushL pulses spaced 3 clk → score 0010000, 0100000, 1000000. Then phase=11, wingame high exactly 1 clk coincident with score=1000000, winner=0. After 8 slowen: phase=00, score=0001000, winner still 0.
- Simultaneous/arbitration: in PLAY at pos=3, assert pushL and pushR in the same cycle → no score change. Next, pushR alone → score=0000100.
- False start to victory: start; before any slowen, issue 3 pushR pulses → score 0010000, 0100000, 1000000. Left wins (winner=0), wingame pulses once, phase=11 without passing through PLAY.
- Async reset mid-VICTORY: drive a right win (winner=1, score=0000001), then assert rst=0 between clock edges → phase=00, score=0001000, winner=0 immediately. The next start/pushes run a normal round.
